// File: rtl/vec_quant_fp6.sv
// vec_quant_fp6: collects a block of signed fixed-point values, derives a shared
// power-of-two scale from the largest magnitude, then re-encodes every element
// as FP6 (E3M2) with round-to-nearest-even and saturation, emitted as one beat.
module vec_quant_fp6 #(
    parameter int exp_width = 3,
    parameter int man_width = 2,
    parameter int length    = 32,
    parameter int fxp_width = 16,
    parameter int scl_width = 8,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int bias      = (1 << (exp_width - 1)) - 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [fxp_width-1:0]               i_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [length-1:0][bit_width-1:0]   o_vec,
    output logic signed [scl_width-1:0]        o_scale
);
    localparam int emax  = ((1 << exp_width) - 1) - bias;
    localparam int cnt_w = (length > 1) ? $clog2(length) : 1;
    localparam int pw    = fxp_width + 1;      // rounding can carry one bit past the input width
    localparam int pmw   = $clog2(pw) + 1;
    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] QUANT   = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    logic [1:0]                         state;
    logic [cnt_w-1:0]                   cnt;
    logic                               run;      // low until the first edge after reset
    logic [pmw-1:0]                     p_max;
    logic                               nz;
    logic signed [scl_width-1:0]        scale;
    logic [fxp_width-1:0]               mem [length];
    logic [length-1:0][bit_width-1:0]   stage;
    logic [length-1:0][bit_width-1:0]   vec_next;

    // Position of the highest set bit (0 for zero input).
    function automatic int lead_pos(input logic [pw-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < pw; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    // Unsigned magnitude; the most negative input maps to 2^(fxp_width-1) exactly.
    function automatic logic [fxp_width-1:0] mag(input logic [fxp_width-1:0] x);
        return x[fxp_width-1] ? (~x + 1'b1) : x;
    endfunction

    logic                  in_fire;
    logic                  last;
    logic [fxp_width-1:0]  in_m;
    int                    in_p;
    int                    p_next;
    logic                  nz_next;

    assign o_ready = run && (state == COLLECT);
    assign o_valid = (state == EMIT);
    assign in_fire = i_valid && o_ready;
    assign last    = (cnt == cnt_w'(length - 1));

    // Running max exponent and nonzero flag including the beat on the bus.
    always_comb begin
        in_m    = mag(i_data);
        in_p    = lead_pos({1'b0, in_m});
        nz_next = nz || (in_m != '0);
        p_next  = int'(p_max);
        if (in_m != '0 && in_p > p_next) p_next = in_p;
    end

    logic [fxp_width-1:0]  q_x;
    logic [fxp_width-1:0]  q_m;
    logic [pw-1:0]         q_q;
    logic [pw-1:0]         q_r;
    logic [pw-1:0]         q_rem;
    logic [pw-1:0]         q_half;
    logic                  q_up;
    int                    s;
    int                    q_p;
    int                    q_k;
    int                    q_lr;
    int                    q_e;
    logic [exp_width-1:0]  q_exp;
    logic [man_width-1:0]  q_man;
    logic [bit_width-1:0]  q_code;

    // Quantize element cnt: choose quantum 2^k, round RNE, then normalize and encode.
    always_comb begin
        q_x    = mem[cnt];
        q_m    = mag(q_x);
        s      = int'(scale);
        q_p    = lead_pos({1'b0, q_m});
        q_k    = ((q_p > s + 1 - bias) ? q_p : (s + 1 - bias)) - man_width;
        q_q    = {1'b0, q_m};
        q_r    = {1'b0, q_m};
        q_rem  = '0;
        q_half = '0;
        q_up   = 1'b0;
        if (q_k > 0) begin
            q_q    = {1'b0, q_m} >> q_k;
            q_rem  = {1'b0, q_m} & ((pw'(1) << q_k) - pw'(1));
            q_half = pw'(1) << (q_k - 1);
            q_up   = (q_rem > q_half) || ((q_rem == q_half) && q_q[0]);
            q_q    = q_q + pw'(q_up);
            q_r    = q_q << q_k;
        end
        q_lr  = lead_pos(q_r);
        q_e   = q_lr - s;
        q_exp = '0;
        if (q_e < 1 - bias) begin
            // subnormal: mantissa is the quotient in units of the subnormal quantum
            q_man = (q_k > 0) ? man_width'(q_q) : man_width'(q_r << (-q_k));
        end else begin
            q_exp = exp_width'(q_e + bias);
            q_man = (q_lr >= man_width) ? man_width'(q_r >> (q_lr - man_width))
                                        : man_width'(q_r << (man_width - q_lr));
        end
        if (q_r == '0)
            q_code = '0;
        else if (q_e > emax)
            q_code = {q_x[fxp_width-1], {(exp_width + man_width){1'b1}}};
        else
            q_code = {q_x[fxp_width-1], q_exp, q_man};
    end

    // Staged vector with the element being quantized this cycle merged in.
    always_comb begin
        vec_next      = stage;
        vec_next[cnt] = q_code;
    end

    // Element buffer; every block overwrites all entries so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (in_fire) mem[cnt] <= i_data;
    end

    // Control FSM, max tracking, scale and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= COLLECT;
            cnt     <= '0;
            run     <= 1'b0;
            p_max   <= '0;
            nz      <= 1'b0;
            scale   <= '0;
            stage   <= '0;
            o_vec   <= '0;
            o_scale <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                COLLECT: if (in_fire) begin
                    if (last) begin
                        state <= QUANT;
                        cnt   <= '0;
                        p_max <= '0;
                        nz    <= 1'b0;
                        scale <= nz_next ? scl_width'(p_next - emax) : '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        p_max <= pmw'(p_next);
                        nz    <= nz_next;
                    end
                end
                QUANT: begin
                    stage <= vec_next;
                    if (last) begin
                        state   <= EMIT;
                        cnt     <= '0;
                        o_vec   <= vec_next;
                        o_scale <= scale;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: if (i_ready) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_quant_fp6.sv
// Directed bench for vec_quant_fp6 with hand-computed FP6 codes and scales.
module tb_vec_quant_fp6;
    localparam int L = 32;

    logic                  i_clk   = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_valid = 1'b0;
    logic                  i_ready = 1'b1;
    logic [15:0]           i_data  = '0;
    logic                  o_ready;
    logic                  o_valid;
    logic [L-1:0][5:0]     o_vec;
    logic signed [7:0]     o_scale;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] din   [L];
    logic [5:0]  ecode [L];
    int          escale;

    always #5 i_clk = ~i_clk;

    vec_quant_fp6 dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_vec   (o_vec),
        .o_scale (o_scale)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] d, input logic [5:0] c, input int sc);
        for (int i = 0; i < L; i++) begin
            din[i]   = d;
            ecode[i] = c;
        end
        escale = sc;
    endtask

    task automatic feed(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = din[i];
            chk($sformatf("%s rdy%0d", tag, i), int'(o_ready), 1);
            @(posedge i_clk); #1;
        end
    endtask

    task automatic run_block(input string tag, input int hold);
        int                n;
        logic [L-1:0][5:0] vsave;
        logic signed [7:0] ssave;
        i_ready = (hold == 0);
        feed(tag, L);
        i_valid = (hold > 0);
        i_data  = 16'h7fff;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, L);
        chk({tag, " scale"}, int'(o_scale), escale);
        for (int i = 0; i < L; i++)
            chk($sformatf("%s e%0d", tag, i), int'(o_vec[i]), int'(ecode[i]));
        if (hold > 0) begin
            vsave = o_vec;
            ssave = o_scale;
            repeat (hold) begin
                @(posedge i_clk); #1;
                chk({tag, " hold valid"}, int'(o_valid), 1);
                chk({tag, " hold ready"}, int'(o_ready), 0);
                chk({tag, " hold vec"}, int'(o_vec == vsave), 1);
                chk({tag, " hold scale"}, int'(o_scale), int'(ssave));
            end
            i_ready = 1'b1;
            i_valid = 1'b0;
        end
        @(posedge i_clk); #1;
        chk({tag, " post valid"}, int'(o_valid), 0);
        chk({tag, " post ready"}, int'(o_ready), 1);
    endtask

    task automatic set_round;
        fill(16'd0, 6'h00, 0);
        din[0] = 16'd16;   ecode[0] = 6'h1C;
        din[1] = 16'd9;    ecode[1] = 6'h18;
        din[2] = 16'd11;   ecode[2] = 6'h1A;
        din[3] = 16'd31;   ecode[3] = 6'h1F;
        din[4] = 16'hFFE1; ecode[4] = 6'h3F;
    endtask

    task automatic set_gap;
        fill(16'd1, 6'h00, 6);
        din[0] = 16'd1024; ecode[0] = 6'h1C;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst ready", int'(o_ready), 0);
        chk("rst valid", int'(o_valid), 0);
        chk("rst scale", int'(o_scale), 0);
        chk("rst vec", int'(o_vec == '0), 1);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rel ready", int'(o_ready), 1);

        fill(16'd7, 6'h1F, -2);
        run_block("sevens", 0);
        set_gap();
        run_block("gap", 0);
        set_round();
        run_block("round", 0);
        fill(16'd0, 6'h00, 0);
        run_block("zero", 0);
        fill(16'd0, 6'h00, 11);
        din[0] = 16'h8000; ecode[0] = 6'h3C;
        run_block("minneg bp", 10);
        fill(16'd7, 6'h1F, -2);
        run_block("sevens nobubble", 0);

        // reset after 10 large beats: no stale P or count may survive
        fill(16'h7fff, 6'h00, 0);
        feed("part", 10);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid rst ready", int'(o_ready), 0);
        chk("mid rst valid", int'(o_valid), 0);
        chk("mid rst scale", int'(o_scale), 0);
        chk("mid rst vec", int'(o_vec == '0), 1);
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        set_round();
        run_block("round after rst", 0);

        // reset while quantizing; o_vec still holds the previous block
        set_gap();
        feed("qpart", L);
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        chk("q rst ready", int'(o_ready), 0);
        chk("q rst valid", int'(o_valid), 0);
        chk("q rst scale", int'(o_scale), 0);
        chk("q rst vec", int'(o_vec == '0), 1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        fill(16'd7, 6'h1F, -2);
        run_block("sevens after qrst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
